// File: rtl/hub75_line_driver.sv
// HUB75 line driver: captures one scan line, shifts it out and shows it with binary-coded modulation.
// Define HUB75_BCM_EN for 3-plane BCM; otherwise only the MSB plane of each channel is shown.

module hub75_half_sel #(
    parameter int NUM_ROWS = 64,
    parameter int RGB_RES  = 9
) (
    input  logic [NUM_ROWS-1:0][RGB_RES-1:0] pixels,
    input  logic [$clog2(NUM_ROWS)-1:0]      pix,
    input  logic [1:0]                       plane,
    output logic [2:0]                       rgb
);
    logic [RGB_RES-1:0] px;

    always_comb px = pixels[pix];

    // rgb[2]=red (bits 8:6), rgb[1]=green (5:3), rgb[0]=blue (2:0)
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [2:0] lane;
        always_comb begin
            lane    = px[ch*3 +: 3];
            rgb[ch] = lane[plane];
        end
    end
endmodule

module hub75_line_driver #(
    parameter int NUM_ROWS  = 64,
    parameter int SCAN_RATE = 32,
    parameter int RGB_RES   = 9,
    parameter int BASE_ON   = 32
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    data_valid,
    input  logic [$clog2(SCAN_RATE)-1:0]            col_num,
    input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns,
    output logic                                    hub75_ready,
    output logic                                    hub75_last,
    output logic                                    hub75_r0,
    output logic                                    hub75_g0,
    output logic                                    hub75_b0,
    output logic                                    hub75_r1,
    output logic                                    hub75_g1,
    output logic                                    hub75_b1,
    output logic                                    hub75_clk,
    output logic                                    hub75_lat,
    output logic                                    hub75_oe,
    output logic [$clog2(SCAN_RATE)-1:0]            hub75_addr
);
    localparam int ADDR_W    = $clog2(SCAN_RATE);
    localparam int PIX_W     = $clog2(NUM_ROWS);
    localparam int SHIFT_LEN = 2 * NUM_ROWS;
    localparam int DISP_MAX  = BASE_ON * 4;
    localparam int CNT_W     = $clog2(((SHIFT_LEN > DISP_MAX) ? SHIFT_LEN : DISP_MAX) + 1);

`ifdef HUB75_BCM_EN
    localparam logic [1:0] PLANE_FIRST = 2'd0;
`else
    localparam logic [1:0] PLANE_FIRST = 2'd2;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t                                 state, state_nxt;
    logic [CNT_W-1:0]                       cnt, cnt_nxt;
    logic [1:0]                             plane, plane_nxt;
    logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  line_q, src;
    logic [ADDR_W-1:0]                      col_q;
    logic [PIX_W-1:0]                       pix_nxt;
    logic [1:0][2:0]                        rgb_nxt;
    logic                                   last_nxt;

    function automatic logic [CNT_W-1:0] disp_len(input logic [1:0] p);
        return CNT_W'(BASE_ON) << p;
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        plane_nxt = plane;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (data_valid) begin
                    state_nxt = SHIFT;
                    plane_nxt = PLANE_FIRST;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(SHIFT_LEN - 1)) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                end
            end
            LATCH: begin
                state_nxt = DISPLAY;
                cnt_nxt   = '0;
            end
            DISPLAY: begin
                if (cnt == disp_len(plane) - 1'b1) begin
                    cnt_nxt = '0;
                    if (plane == 2'd2) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SHIFT;
                        plane_nxt = plane + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        last_nxt = (state_nxt == DISPLAY) && (plane_nxt == 2'd2) &&
                   (cnt_nxt == disp_len(2'd2) - 1'b1);
    end

    // Outputs are registered from next-state values, so the first pixel has to come
    // straight from the inputs on the capture edge.
    always_comb begin
        src     = (state == IDLE) ? columns : line_q;
        pix_nxt = cnt_nxt[PIX_W:1];
    end

    for (genvar h = 0; h < 2; h++) begin : g_half
        hub75_half_sel #(.NUM_ROWS(NUM_ROWS), .RGB_RES(RGB_RES)) u_sel (
            .pixels (src[h]),
            .pix    (pix_nxt),
            .plane  (plane_nxt),
            .rgb    (rgb_nxt[h])
        );
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            cnt         <= '0;
            plane       <= '0;
            line_q      <= '0;
            col_q       <= '0;
            hub75_ready <= 1'b0;
            hub75_last  <= 1'b0;
            hub75_oe    <= 1'b1;
            hub75_lat   <= 1'b0;
            hub75_clk   <= 1'b0;
            hub75_addr  <= '0;
            {hub75_r0, hub75_g0, hub75_b0} <= 3'b000;
            {hub75_r1, hub75_g1, hub75_b1} <= 3'b000;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            plane <= plane_nxt;
            if (state == IDLE && data_valid) begin
                line_q <= columns;
                col_q  <= col_num;
            end
            hub75_ready <= (state_nxt == IDLE);
            hub75_last  <= last_nxt;
            hub75_oe    <= (state_nxt != DISPLAY);
            hub75_lat   <= (state_nxt == LATCH);
            hub75_clk   <= (state_nxt == SHIFT) && cnt_nxt[0];
            if (state_nxt == LATCH)
                hub75_addr <= col_q;
            if (state_nxt == SHIFT) begin
                {hub75_r0, hub75_g0, hub75_b0} <= rgb_nxt[0];
                {hub75_r1, hub75_g1, hub75_b1} <= rgb_nxt[1];
            end
        end
    end
endmodule
